// File: rtl/msg_buffer.sv
// Per-source message buffer: groups an incoming byte stream into messages
// and presents them as a show-ahead byte queue plus a head length.
module msg_buffer #(
  parameter int DEPTH     = 256,
  parameter int LEN_DEPTH = 16,
  parameter int MAX_LEN   = 255,
  parameter int TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       have_msg,
  output logic [7:0] len,
  output logic [7:0] data,
  input  logic       rdreq,
  output logic       err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [7:0]    mem_q  [DEPTH];
  logic [7:0]    lmem_q [LEN_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW:0]   lwr_q, lwr_d, lrd_q, lrd_d;
  logic [7:0]    open_q, open_d;
  logic [7:0]    rdc_q, rdc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          err_q, err_d;

  logic          byte_empty, byte_full;
  logic          len_empty, len_full;
  logic [AW:0]   byte_cnt;
  logic [8:0]    open_nx;
  logic [7:0]    len_head, push_len;
  logic          accept, pop, fill, close;
  logic          tmo, lpush, lpop;

  always_comb begin
    byte_empty = (wr_q == rd_q);
    byte_full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
    len_empty  = (lwr_q == lrd_q);
    len_full   = (lwr_q[LW] != lrd_q[LW]) &&
                 (lwr_q[LW-1:0] == lrd_q[LW-1:0]);
    byte_cnt   = wr_q - rd_q;
    len_head   = lmem_q[lrd_q[LW-1:0]];
    in_ready   = !byte_full && !len_full;
    accept     = in_valid && in_ready;
    pop        = rdreq && !byte_empty;
    open_nx    = {1'b0, open_q} + 9'd1;
    // Closing on a filling byte keeps a max-length message from deadlocking
    fill       = (byte_cnt == (AW+1)'(DEPTH - 1)) && !pop;
    close      = accept &&
                 (in_last || (open_nx == 9'(MAX_LEN)) || fill);
    tmo        = !accept && (open_q != 8'd0) && (TIMEOUT != 0) &&
                 (idle_q == IW'(TIMEOUT - 1));
    lpush      = close || tmo;
    push_len   = close ? open_nx[7:0] : open_q;
    lpop       = pop && !len_empty && ((rdc_q + 8'd1) == len_head);

    wr_d   = accept ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    lwr_d  = lpush ? lwr_q + 1'b1 : lwr_q;
    lrd_d  = lpop ? lrd_q + 1'b1 : lrd_q;
    err_d  = err_q || (rdreq && byte_empty);

    open_d = open_q;
    if (lpush)       open_d = 8'd0;
    else if (accept) open_d = open_nx[7:0];

    idle_d = idle_q;
    if (accept || tmo)
      idle_d = '0;
    else if (open_q != 8'd0 && TIMEOUT != 0)
      idle_d = idle_q + 1'b1;

    rdc_d = rdc_q;
    if (lpop)     rdc_d = 8'd0;
    else if (pop) rdc_d = rdc_q + 8'd1;

    have_msg      = !len_empty;
    len           = len_empty ? 8'd0 : len_head;
    data          = byte_empty ? 8'd0 : mem_q[rd_q[AW-1:0]];
    err_underflow = err_q;
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q[AW-1:0]] <= in_data;
    if (lpush)  lmem_q[lwr_q[LW-1:0]] <= push_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lwr_q  <= '0;
      lrd_q  <= '0;
      open_q <= '0;
      rdc_q  <= '0;
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lwr_q  <= lwr_d;
      lrd_q  <= lrd_d;
      open_q <= open_d;
      rdc_q  <= rdc_d;
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_msg_buffer.sv
// Randomized bench for msg_buffer against a queue-based message model.
// Small parameters so byte-full, length-full and timeout are reachable.
module tb_msg_buffer;

  localparam int DEPTH     = 16;
  localparam int LEN_DEPTH = 8;
  localparam int MAX_LEN   = 12;
  localparam int TIMEOUT   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       have_msg;
  logic [7:0] len;
  logic [7:0] data;
  logic       rdreq = 1'b0;
  logic       err_underflow;

  msg_buffer #(
    .DEPTH(DEPTH), .LEN_DEPTH(LEN_DEPTH),
    .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .have_msg(have_msg), .len(len), .data(data),
    .rdreq(rdreq), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  byte unsigned bq[$];
  int lq[$];
  int m_open, m_idle, m_rdc;
  bit m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return bq.size() < DEPTH && lq.size() < LEN_DEPTH;
  endfunction

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("have_msg", 32'(have_msg), 32'(lq.size() > 0));
    chk("len", 32'(len), (lq.size() > 0) ? 32'(lq[0]) : 0);
    chk("data", 32'(data), (bq.size() > 0) ? 32'(bq[0]) : 0);
    chk("err", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic step(input bit v, input bit [7:0] d,
                      input bit l, input bit r);
    bit acc, pop;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    rdreq    = r;
    acc = v && m_ready();
    pop = r && bq.size() > 0;
    @(posedge clk);
    if (rst) begin
      bq.delete();
      lq.delete();
      m_open = 0; m_idle = 0; m_rdc = 0; m_err = 0;
    end else begin
      if (r && bq.size() == 0) m_err = 1;
      if (pop) begin
        void'(bq.pop_front());
        m_rdc++;
        if (lq.size() > 0 && m_rdc == lq[0]) begin
          void'(lq.pop_front());
          m_rdc = 0;
        end
      end
      if (acc) begin
        bq.push_back(d);
        m_open++;
        m_idle = 0;
        if (l || m_open == MAX_LEN || bq.size() == DEPTH) begin
          lq.push_back(m_open);
          m_open = 0;
        end
      end else if (m_open != 0 && TIMEOUT != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          lq.push_back(m_open);
          m_open = 0;
          m_idle = 0;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && lq.size() > 0; i++)
      step(0, 8'h00, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_have_msg", 32'(have_msg), 0);
    chk("rst_len", 32'(len), 0);
    chk("rst_data", 32'(data), 0);

    // Basic three-byte message
    step(1, 8'h11, 0, 0);
    chk("first_data", 32'(data), 32'h11);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 1, 0);
    chk("basic_have", 32'(have_msg), 1);
    chk("basic_len", 32'(len), 3);
    step(0, 8'h00, 0, 1);
    chk("basic_d1", 32'(data), 32'h22);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("basic_done", 32'(have_msg), 0);

    // Max-length close, then forced close on byte-full
    for (int i = 0; i < DEPTH; i++)
      step(1, 8'(i + 1), 0, 0);
    chk("full_ready", 32'(in_ready), 0);
    chk("maxlen_len", 32'(len), 12);
    step(1, 8'hEE, 0, 1);
    chk("full_pop_ready", 32'(in_ready), 1);
    chk("full_pop_data", 32'(data), 2);
    drain();
    chk("full_drained", 32'(have_msg), 0);

    // Length FIFO full with one-byte messages
    do_reset();
    for (int i = 0; i < LEN_DEPTH; i++)
      step(1, 8'(8'h40 + i), 1, 0);
    chk("lfull_ready", 32'(in_ready), 0);
    chk("lfull_len", 32'(len), 1);
    step(0, 8'h00, 0, 1);
    chk("lfull_pop_ready", 32'(in_ready), 1);
    drain();

    // Idle timeout closes an open message
    step(1, 8'h51, 0, 0);
    step(1, 8'h52, 0, 0);
    step(1, 8'h53, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++)
      step(0, 8'h00, 0, 0);
    chk("tmo_early", 32'(have_msg), 0);
    step(0, 8'h00, 0, 0);
    chk("tmo_have", 32'(have_msg), 1);
    chk("tmo_len", 32'(len), 3);
    drain();

    // Close of B on the same edge as last-byte pop of A
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 1, 0);
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 1);
    step(1, 8'hB3, 1, 1);
    chk("same_edge_have", 32'(have_msg), 1);
    chk("same_edge_len", 32'(len), 3);
    chk("same_edge_data", 32'(data), 32'hB1);
    drain();

    // Random traffic with pointer wrap
    for (int i = 0; i < 3000; i++) begin
      bit v, l, r;
      v = $urandom_range(0, 99) < 70;
      l = $urandom_range(0, 99) < 20;
      r = (lq.size() > 0) && ($urandom_range(0, 99) < 60);
      step(v, 8'($urandom), l, r);
    end
    drain();

    // Continuous write and read
    for (int i = 0; i < 1200; i++) begin
      bit l;
      l = $urandom_range(0, 99) < 15;
      step(1, 8'($urandom), l, lq.size() > 0);
    end
    drain();

    // Underflow is sticky until reset; reset mid-message
    do_reset();
    step(0, 8'h00, 0, 1);
    chk("uflow_set", 32'(err_underflow), 1);
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 1, 0);
    chk("uflow_sticky", 32'(err_underflow), 1);
    step(1, 8'h63, 0, 0);
    do_reset();
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_have", 32'(have_msg), 0);
    chk("mid_len", 32'(len), 0);
    chk("mid_data", 32'(data), 0);
    chk("mid_err", 32'(err_underflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_buffer.md
# msg_buffer

Per-source message buffer feeding the command encoder. Accepts a byte stream from one source (UART/SPI receiver, status poller, …), groups bytes into messages, and presents each complete message as a show-ahead byte queue plus an 8-bit length. One instance per source; the `N_SRC` instances' `have_msg`/`data`/`len`/`rdreq` are concatenated into the encoder's `have_msg_bus`/`data_bus`/`len_bus`/`rdreq_bus`.

## Interface
- `DEPTH`, 256: byte storage depth; power of two, ≥ 4.
- `LEN_DEPTH`, 16: number of closed messages held; power of two.
- `MAX_LEN`, 255: maximum message length in bytes; 1..255.
- `TIMEOUT`, 1000: idle cycles after which an open message is closed; 0 disables.

- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  incoming byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  `in_data` is the last byte of a message.
- `in_ready`  out  1  byte accepted on an edge with `in_valid & in_ready`.
- `have_msg`  out  1  at least one complete message stored.
- `len`  out  8  length of the head message; valid while `have_msg`.
- `data`  out  8  head byte (show-ahead).
- `rdreq`  in  1  pop one byte.
- `err_underflow`  out  1  sticky: `rdreq` seen while byte queue empty.

## Operation
- Storage: byte FIFO (`DEPTH` × 8, show-ahead) and length FIFO (`LEN_DEPTH` × 8).
- `open_cnt` (8 bit): bytes of the message currently being written.
- Message closes on the accept edge of a byte when any holds:
  - `in_last`;
  - `open_cnt + 1 == MAX_LEN`;
  - the byte fills the byte FIFO (forced close, avoids deadlock).
- On close: `open_cnt + 1` is pushed to the length FIFO and `open_cnt` clears.
- Idle close: while `open_cnt != 0` and no byte is accepted, `idle_cnt` increments.
  - When `idle_cnt` reaches `TIMEOUT`, `open_cnt` is pushed and both counters clear.
  - Any accepted byte clears `idle_cnt`.
- No zero-length message is ever pushed; `len` ≥ 1 whenever `have_msg`.
- `in_ready = !byte_full & !len_full`.
- Read side:
  - `have_msg = !len_empty`; `len` = length FIFO head.
  - `rdreq` pops one byte and increments `rd_cnt`.
  - When `rd_cnt + 1 == len` on a pop, the length FIFO pops and `rd_cnt` clears.
- `rdreq` while byte FIFO empty: no pointer change; sets `err_underflow`.
- Simultaneous write and pop on the same edge: both take effect; occupancy is unchanged.
- Simultaneous length push (close) and length pop: both take effect.
- Pointer wrap is by natural modulo of `log2(DEPTH)` / `log2(LEN_DEPTH)`-bit pointers. Full/empty come from an extra MSB pointer bit.

## Timing
- Reset values:
  - `in_ready` = 1;
  - `have_msg` = 0;
  - `len` = 0;
  - `data` = 0 (forced 0 while byte FIFO empty);
  - `err_underflow` = 0.
- Reset also clears all pointers and counters. Reset mid-message discards all stored and open data.
- Write-to-data latency: a byte accepted into an empty FIFO appears on `data` the next cycle.
- Close-to-`have_msg` latency: 1 cycle after the closing edge (or the timeout edge).
- Pop: `data` shows the next byte the cycle after the `rdreq` edge.
- Last-byte pop: `have_msg` falls the cycle after the edge, unless another message is queued, in which case `len` updates that same cycle.
- `len` and `have_msg` stay stable while a message is being read. The encoder samples `len` once per message.
- `rdreq` may be asserted every cycle; full throughput is 1 byte/cycle in each direction.

## Test plan
- Reset, then write 3 bytes 0x11,0x22,0x33 with `in_last` on the third → `have_msg`=1, `len`=3 next cycle. 3 `rdreq` pulses read 0x11,0x22,0x33, then `have_msg`=0.
- `MAX_LEN`=4: write 10 bytes with no `in_last` and no gaps → messages of length 4, 4 queued. After `TIMEOUT` idle cycles a third message of length 2 appears; no length-0 entry.
- Fill to `DEPTH` without `in_last` → forced close at byte `DEPTH` (if below `MAX_LEN`); `in_ready`=0 until the first pop; no byte lost.
- Close 16 one-byte messages (`LEN_DEPTH`=16) → `in_ready`=0. One pop → `in_ready`=1 next cycle. Continuous write + read for 1000 bytes with pointer wrap → output sequence equals input.
- Same-edge close of message B and last-byte pop of message A → `len` switches to B's length, `have_msg` stays 1.
- `rdreq` on empty buffer → `err_underflow`=1 until `rst`. Assert `rst` mid-message → all outputs return to reset values the next cycle.
